// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution datapath.
//   ram_state_t  : clear-sweep FSM states used by param_ram_sweep
//   CONV_DATA_W  : default pixel/kernel word width
//   CONV_DEPTH   : default number of words per parameter RAM
// -----------------------------------------------------------------------------
package conv_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } ram_state_t;

  localparam int CONV_DATA_W = 8;
  localparam int CONV_DEPTH  = 16;

endpackage : conv_pkg

// File: rtl/param_ram_sweep.sv
// -----------------------------------------------------------------------------
// param_ram_sweep
// Clear-sweep controller for param_ram. After reset, or on init_req while
// idle, it walks every address from 0 to DEPTH-1, one per clock, and asks the
// RAM to write its init value there.
// Ports:
//   i_clk        : clock, rising edge
//   i_clr_n      : asynchronous active-low reset (restarts the sweep at 0)
//   i_init_req   : start a new sweep, honoured only while idle
//   o_busy       : high for the whole sweep
//   o_sweep_we   : write strobe for the init value
//   o_sweep_addr : address currently being cleared
// -----------------------------------------------------------------------------
module param_ram_sweep
  import conv_pkg::*;
#(
  parameter int DEPTH  = CONV_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_clr_n,
  input  logic              i_init_req,
  output logic              o_busy,
  output logic              o_sweep_we,
  output logic [ADDR_W-1:0] o_sweep_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ram_state_t        r_state;
  ram_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    o_busy       = 1'b0;
    o_sweep_we   = 1'b0;
    o_sweep_addr = r_cnt;
    case (r_state)
      ST_INIT: begin
        o_busy     = 1'b1;
        o_sweep_we = 1'b1;
        // The last entry is written on the same edge that leaves INIT.
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        if (i_init_req) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule : param_ram_sweep

// File: rtl/param_ram.sv
// -----------------------------------------------------------------------------
// param_ram
// Parametrised one-write/one-read memory for the convolution engine. Registered
// read with a valid pulse, selectable read-during-write result, out-of-range
// detection and a clear sweep after reset or on request.
// Ports:
//   clk      : clock, rising edge
//   clr_n    : asynchronous active-low reset
//   init_req : start a clear sweep (idle only)
//   busy     : high while the sweep runs; all accesses are ignored then
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr         : read port
//   rd_data  : registered read data, held until the next accepted read
//   rd_valid : one-cycle pulse, rd_data was updated
//   err      : one-cycle pulse, an out-of-range access happened last cycle
// -----------------------------------------------------------------------------
module param_ram
  import conv_pkg::*;
#(
  parameter int                DATA_W   = CONV_DATA_W,
  parameter int                DEPTH    = CONV_DEPTH,
  parameter int                ADDR_W   = $clog2(DEPTH),
  parameter bit                BYPASS   = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              init_req,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              err
);

  // One extra bit so DEPTH itself is representable when it is a power of 2.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_err;

  logic              w_busy;
  logic              w_sweep_we;
  logic [ADDR_W-1:0] w_sweep_addr;
  logic              w_wr_in_rng;
  logic              w_rd_in_rng;
  logic              w_wr_ok;
  logic              w_rd_acc;
  logic              w_err_nxt;
  logic [DATA_W-1:0] w_rd_word;

  param_ram_sweep #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_sweep (
    .i_clk        (clk),
    .i_clr_n      (clr_n),
    .i_init_req   (init_req),
    .o_busy       (w_busy),
    .o_sweep_we   (w_sweep_we),
    .o_sweep_addr (w_sweep_addr)
  );

  assign w_wr_in_rng = ({1'b0, wr_addr} < DEPTH_L);
  assign w_rd_in_rng = ({1'b0, rd_addr} < DEPTH_L);
  assign w_wr_ok     = !w_busy && wr_en && w_wr_in_rng;
  assign w_rd_acc    = !w_busy && rd_en;
  // Both ports out of range in one cycle still give a single pulse.
  assign w_err_nxt   = !w_busy && ((wr_en && !w_wr_in_rng) || (rd_en && !w_rd_in_rng));

  always_comb begin
    w_rd_word = '0;
    if (w_rd_in_rng) begin
      if (BYPASS && w_wr_ok && (wr_addr == rd_addr)) begin
        w_rd_word = wr_data;
      end else begin
        w_rd_word = r_mem[rd_addr];
      end
    end
  end

  // Array has no reset; the sweep is what clears it.
  always_ff @(posedge clk) begin
    if (w_sweep_we) begin
      r_mem[w_sweep_addr] <= INIT_VAL;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      r_err      <= w_err_nxt;
      if (w_rd_acc) begin
        r_rd_data <= w_rd_word;
      end
    end
  end

  assign busy     = w_busy;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign err      = r_err;

endmodule : param_ram

// File: tb/tb_param_ram.sv
// -----------------------------------------------------------------------------
// tb_param_ram
// Three param_ram instances share one stimulus stream:
//   0: DEPTH=16, BYPASS=1, INIT_VAL=0x00
//   1: DEPTH=16, BYPASS=0, INIT_VAL=0x00
//   2: DEPTH=10, BYPASS=1, INIT_VAL=0x5A
// A behavioural model (array + sweep countdown) predicts each instance.
// -----------------------------------------------------------------------------
module tb_param_ram;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       init_req;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [3:0] rd_addr;

  logic       busy_o     [3];
  logic [7:0] rd_data_o  [3];
  logic       rd_valid_o [3];
  logic       err_o      [3];

  int         DEP [3] = '{16, 16, 10};
  bit         BYP [3] = '{1'b1, 1'b0, 1'b1};
  logic [7:0] IV  [3] = '{8'h00, 8'h00, 8'h5A};

  // Reference model state
  logic [7:0] e_mem  [3][16];
  int         e_left [3];
  logic [7:0] e_rd   [3];
  logic       e_vld  [3];
  logic       e_err  [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  param_ram #(.DATA_W(8), .DEPTH(16), .BYPASS(1'b1), .INIT_VAL(8'h00)) u0 (
    .clk(clk), .clr_n(clr_n), .init_req(init_req), .busy(busy_o[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[0]),
    .rd_valid(rd_valid_o[0]), .err(err_o[0]));

  param_ram #(.DATA_W(8), .DEPTH(16), .BYPASS(1'b0), .INIT_VAL(8'h00)) u1 (
    .clk(clk), .clr_n(clr_n), .init_req(init_req), .busy(busy_o[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[1]),
    .rd_valid(rd_valid_o[1]), .err(err_o[1]));

  param_ram #(.DATA_W(8), .DEPTH(10), .BYPASS(1'b1), .INIT_VAL(8'h5A)) u2 (
    .clk(clk), .clr_n(clr_n), .init_req(init_req), .busy(busy_o[2]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[2]),
    .rd_valid(rd_valid_o[2]), .err(err_o[2]));

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      e_left[i] = DEP[i];
      e_rd[i]   = 8'h00;
      e_vld[i]  = 1'b0;
      e_err[i]  = 1'b0;
    end
  endtask

  // Apply one cycle of stimulus (caller is at a negedge), advance the model
  // by one clock, and return at the following negedge.
  task automatic step(input bit we, input logic [3:0] wa, input logic [7:0] wd,
                      input bit re, input logic [3:0] ra, input bit ir);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra; init_req = ir;
    for (int i = 0; i < 3; i++) begin
      if (e_left[i] > 0) begin
        e_left[i] = e_left[i] - 1;
        if (e_left[i] == 0)
          for (int j = 0; j < 16; j++) e_mem[i][j] = IV[i];
        e_vld[i] = 1'b0;
        e_err[i] = 1'b0;
      end else begin
        e_vld[i] = re;
        e_err[i] = (we && int'(wa) >= DEP[i]) || (re && int'(ra) >= DEP[i]);
        if (re) begin
          if (int'(ra) >= DEP[i])              e_rd[i] = 8'h00;
          else if (we && wa == ra && BYP[i])   e_rd[i] = wd;
          else                                 e_rd[i] = e_mem[i][ra];
        end
        if (we && int'(wa) < DEP[i]) e_mem[i][wa] = wd;
        if (ir) e_left[i] = DEP[i];
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int done_at [3];
    clr_n = 1'b0; init_req = 0; wr_en = 0; rd_en = 0;
    wr_addr = 0; rd_addr = 0; wr_data = 0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({busy_o[i], rd_valid_o[i], err_o[i], rd_data_o[i]} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
        n_bad++;
        $display("FAIL reset_vals[%0d]: got busy/vld/err/data=%b/%b/%b/%h want 1/0/0/00",
                 i, busy_o[i], rd_valid_o[i], err_o[i], rd_data_o[i]);
      end
    end
    clr_n = 1'b1;
    done_at = '{0, 0, 0};
    for (int e = 1; e <= 40; e++) begin
      step(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++)
        if (done_at[i] == 0 && !busy_o[i]) done_at[i] = e;
      if (done_at[0] != 0 && done_at[1] != 0 && done_at[2] != 0) break;
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (done_at[i] != DEP[i]) begin
        n_bad++;
        $display("FAIL busy_len[%0d]: got %0d cycles want %0d", i, done_at[i], DEP[i]);
      end
    end
    for (int a = 0; a < 16; a++) begin
      step(0, 0, 0, 1, 4'(a), 0);
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (rd_data_o[i] !== ((a < DEP[i]) ? IV[i] : 8'h00) || rd_valid_o[i] !== 1'b1) begin
          n_bad++;
          $display("FAIL cleared_rd[%0d] addr %0d: got data=%h vld=%b want %h/1",
                   i, a, rd_data_o[i], rd_valid_o[i], (a < DEP[i]) ? IV[i] : 8'h00);
        end
      end
    end
  endtask

  task automatic test_write_read();
    step(1, 4'd3, 8'hA5, 0, 0, 0);
    step(0, 0, 0, 1, 4'd3, 0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rd_data_o[i] !== 8'hA5 || rd_valid_o[i] !== 1'b1) begin
        n_bad++;
        $display("FAIL wr_rd[%0d]: got data=%h vld=%b want a5/1", i, rd_data_o[i], rd_valid_o[i]);
      end
    end
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rd_valid_o[i] !== 1'b0 || rd_data_o[i] !== 8'hA5) begin
        n_bad++;
        $display("FAIL vld_pulse[%0d]: got data=%h vld=%b want a5/0", i, rd_data_o[i], rd_valid_o[i]);
      end
    end
  endtask

  task automatic test_bypass();
    logic [7:0] want [3];
    want = '{8'h3C, 8'h11, 8'h3C};
    step(1, 4'd7, 8'h11, 0, 0, 0);
    step(1, 4'd7, 8'h3C, 1, 4'd7, 0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rd_data_o[i] !== want[i] || rd_valid_o[i] !== 1'b1) begin
        n_bad++;
        $display("FAIL rdw[%0d]: got data=%h vld=%b want %h/1", i, rd_data_o[i], rd_valid_o[i], want[i]);
      end
    end
    step(0, 0, 0, 1, 4'd7, 0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rd_data_o[i] !== 8'h3C) begin
        n_bad++;
        $display("FAIL rdw_after[%0d]: got %h want 3c", i, rd_data_o[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] want_rd [3];
    step(1, 4'd12, 8'h77, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (err_o[i] !== (i == 2)) begin
        n_bad++;
        $display("FAIL oor_wr_err[%0d]: got %b want %b", i, err_o[i], (i == 2));
      end
    end
    step(0, 0, 0, 1, 4'd12, 0);
    want_rd = '{8'h77, 8'h77, 8'h00};
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({rd_data_o[i], rd_valid_o[i], err_o[i]} !== {want_rd[i], 1'b1, (i == 2)}) begin
        n_bad++;
        $display("FAIL oor_rd[%0d]: got data=%h vld=%b err=%b want %h/1/%b",
                 i, rd_data_o[i], rd_valid_o[i], err_o[i], want_rd[i], (i == 2));
      end
    end
    step(1, 4'd13, 8'h22, 1, 4'd14, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (err_o[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL err_single[%0d]: got %b want 0", i, err_o[i]);
      end
    end
  endtask

  task automatic test_random();
    bit         we, re, ir;
    logic [3:0] wa, ra;
    logic [7:0] wd;
    for (int c = 0; c < 400; c++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      ir = ($urandom_range(0, 49) == 0);
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      wd = 8'($urandom);
      step(we, wa, wd, re, ra, ir);
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if ({busy_o[i], rd_valid_o[i], err_o[i], rd_data_o[i]} !==
            {(e_left[i] != 0), e_vld[i], e_err[i], e_rd[i]}) begin
          n_bad++;
          $display("FAIL rand[%0d] cyc %0d: got busy/vld/err/data=%b/%b/%b/%h want %b/%b/%b/%h",
                   i, c, busy_o[i], rd_valid_o[i], err_o[i], rd_data_o[i],
                   (e_left[i] != 0), e_vld[i], e_err[i], e_rd[i]);
        end
      end
    end
    for (int c = 0; c < 20 && busy_o[0]; c++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_init_sweep();
    int waited;
    for (int a = 0; a < 16; a++) step(1, 4'(a), 8'hFF, 0, 0, 0);
    // Request sweep together with a write+read; both still happen.
    step(1, 4'd2, 8'h33, 1, 4'd2, 1);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({busy_o[i], rd_valid_o[i], rd_data_o[i]} !== {1'b1, 1'b1, e_rd[i]}) begin
        n_bad++;
        $display("FAIL init_req_op[%0d]: got busy/vld/data=%b/%b/%h want 1/1/%h",
                 i, busy_o[i], rd_valid_o[i], rd_data_o[i], e_rd[i]);
      end
    end
    for (int c = 0; c < 9; c++) begin
      step(1, 4'($urandom_range(0, 15)), 8'($urandom), 1, 4'($urandom_range(0, 15)), 1);
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if ({busy_o[i], rd_valid_o[i], err_o[i]} !== 3'b100) begin
          n_bad++;
          $display("FAIL busy_ignore[%0d] cyc %0d: got busy/vld/err=%b/%b/%b want 1/0/0",
                   i, c, busy_o[i], rd_valid_o[i], err_o[i]);
        end
      end
    end
    waited = 0;
    while (busy_o[0] && waited < 30) begin
      step(0, 0, 0, 0, 0, 0);
      waited++;
    end
    n_cmp++;
    if (busy_o[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL sweep_end: busy still %b after %0d cycles", busy_o[0], waited);
    end
    for (int a = 0; a < 16; a++) begin
      step(0, 0, 0, 1, 4'(a), 0);
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (rd_data_o[i] !== ((a < DEP[i]) ? IV[i] : 8'h00) || rd_valid_o[i] !== 1'b1) begin
          n_bad++;
          $display("FAIL swept_rd[%0d] addr %0d: got data=%h vld=%b want %h/1",
                   i, a, rd_data_o[i], rd_valid_o[i], (a < DEP[i]) ? IV[i] : 8'h00);
        end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int done_at [3];
    step(1, 4'd1, 8'h3C, 0, 0, 0);
    step(0, 0, 0, 1, 4'd1, 0);
    step(0, 0, 0, 0, 0, 1);
    repeat (5) step(0, 0, 0, 0, 0, 0);
    clr_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({busy_o[i], rd_valid_o[i], err_o[i], rd_data_o[i]} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
        n_bad++;
        $display("FAIL mid_reset[%0d]: got busy/vld/err/data=%b/%b/%b/%h want 1/0/0/00",
                 i, busy_o[i], rd_valid_o[i], err_o[i], rd_data_o[i]);
      end
    end
    @(negedge clk);
    clr_n = 1'b1;
    done_at = '{0, 0, 0};
    for (int e = 1; e <= 40; e++) begin
      step(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++)
        if (done_at[i] == 0 && !busy_o[i]) done_at[i] = e;
      if (done_at[0] != 0 && done_at[1] != 0 && done_at[2] != 0) break;
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (done_at[i] != DEP[i]) begin
        n_bad++;
        $display("FAIL busy_len_again[%0d]: got %0d cycles want %0d", i, done_at[i], DEP[i]);
      end
    end
    step(0, 0, 0, 1, 4'd1, 0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rd_data_o[i] !== IV[i]) begin
        n_bad++;
        $display("FAIL reswept_rd[%0d]: got %h want %h", i, rd_data_o[i], IV[i]);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_out_of_range();
    test_random();
    test_init_sweep();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_param_ram
